nbit_serial_sub: RTL and testbench
==================================

// Module: nbit_serial_sub
// PURPOSE
//   Multi-cycle N-bit subtractor: computes a - b - b_in one bit per clock, LSB first.
//   It is the inverse counterpart of the registered N-bit adder datapath.
//   select=1 gives the bitwise complement of a in a single cycle.
//   Sits beside the adder in the ALU datapath. A start/busy/done handshake lets a
//   controller issue an operation and wait for a registered, held result.
// PARAMETERS
//   n  8  operand/result width in bits; n >= 2; step counter is $clog2(n)+1 bits
// PORTS
//   clk     input   1  single clock; all state updates on rising edge
//   rst_n   input   1  asynchronous, active-low reset
//   start   input   1  request; sampled only in IDLE
//   select  input   1  sampled with start; 0 = subtract, 1 = complement of a
//   a       input   n  minuend; captured when start is accepted
//   b       input   n  subtrahend; captured when start is accepted
//   b_in    input   1  borrow-in; captured when start is accepted
//   diff    output  n  registered result; held until the next completion
//   b_out   output  1  registered final borrow; 1 iff a < b + b_in (unsigned)
//   busy    output  1  high while in SHIFT
//   done    output  1  one-cycle completion pulse; diff/b_out valid while high
// BEHAVIOUR
//   Reset (rst_n=0, any time, async):
//   - state=IDLE; diff=0, b_out=0, busy=0, done=0.
//   - Internal shift regs, borrow flop and counter cleared.
//   - An operation in flight is aborted and discarded.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE:
//   - start=1, select=0: capture a, b, b_in into internal regs; cnt=0; -> SHIFT.
//   - start=1, select=1: diff<=~a, b_out<=0; -> DONE (latency 1 edge).
//   - start=0: stay.
//   SHIFT (busy=1), one bit per edge:
//   - ai/bi = current LSBs; br = borrow flop.
//   - d  = ai^bi^br.
//   - br' = (~ai&bi) | (~(ai^bi)&br).
//   - d shifted into result reg MSB-side; a/b regs shift right; cnt++.
//   - On the edge processing bit n-1: diff<=full result, b_out<=br'; -> DONE.
//   - SHIFT lasts exactly n edges; done rises n edges after the accept edge.
//   DONE: done=1, busy=0 for exactly one cycle; -> IDLE. start ignored here.
//   Handshake:
//   - start ignored outside IDLE; no queuing.
//   - Changes on a/b/b_in/select after accept have no effect.
//   - Subtract throughput: one op per n+2 cycles.
//   Width/arithmetic:
//   - Result is modulo 2^n; wrap-around is signalled only via b_out.
//   - b_in joins the chain as the initial borrow at bit 0.
//   diff/b_out change only on a completion edge or reset; stable while busy.
//   busy and done are never high together.
// TESTING
//   1. a=8'h3C, b=8'h1A, b_in=0, sel=0 -> done 8 edges after accept; diff=8'h22, b_out=0.
//   2. a=8'h05, b=8'h07, b_in=0 -> diff=8'hFE, b_out=1.
//   3. a=8'h00, b=8'h00, b_in=1 -> diff=8'hFF, b_out=1 (wrap); a=b=8'hFF, b_in=0 -> 8'h00, 0.
//   4. sel=1, a=8'hA5 -> done next cycle; diff=8'h5A, b_out=0; busy never asserted.
//   5. start held high during SHIFT/DONE with new a/b -> ignored; result from captured
//      operands; next start accepted only once back in IDLE.
//   6. rst_n low at the 4th SHIFT cycle -> diff=0, b_out=busy=done=0 immediately.
//      After release: start with a=8'h10, b=8'h01 -> diff=8'h0F, b_out=0.
//   Bench: checker compares every done pulse against (a-b-b_in) mod 2^n plus borrow
//   over >=1000 random ops at n=8 and n=16.

Source files
------------

// File: rtl/nbit_serial_sub_if.sv
// Handshake and operand/result bundle for the serial subtractor.
// master = controller side, slave = subtractor side.
interface nbit_serial_sub_if #(
    parameter int unsigned n = 8
);
    logic         start;
    logic         select;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         b_in;
    logic [n-1:0] diff;
    logic         b_out;
    logic         busy;
    logic         done;

    modport master (
        output start, select, a, b, b_in,
        input  diff, b_out, busy, done
    );

    modport slave (
        input  start, select, a, b, b_in,
        output diff, b_out, busy, done
    );
endinterface

// File: rtl/nbit_serial_sub.sv
// Bit-serial n-bit subtractor (a - b - b_in, LSB first) with a one-cycle complement path.
// Results are registered and held until the next completion.
module nbit_serial_sub #(
    parameter int unsigned n = 8
) (
    input logic              clk,
    input logic              rst_n,
    nbit_serial_sub_if.slave bus
);
    localparam int unsigned CntW = $clog2(n) + 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [n-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic            br_q, br_d, b_out_q, b_out_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ai, bi, d_bit, br_next, last_bit;

    assign ai       = a_q[0];
    assign bi       = b_q[0];
    assign d_bit    = ai ^ bi ^ br_q;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign last_bit = (cnt_q == CntW'(n - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = bus.select ? StDone : StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q == StShift);
        bus.done  = (state_q == StDone);
        bus.diff  = diff_q;
        bus.b_out = b_out_q;
    end

    // Datapath next-state; operands are only sampled on the accept edge.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.select) begin
                        diff_d  = ~bus.a;
                        b_out_d = 1'b0;
                    end else begin
                        a_d   = bus.a;
                        b_d   = bus.b;
                        br_d  = bus.b_in;
                        res_d = '0;
                        cnt_d = '0;
                    end
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[n-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_bit) begin
                    diff_d  = {d_bit, res_q[n-1:1]};
                    b_out_d = br_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
        end
    end
endmodule

// File: tb/tb_nbit_serial_sub.sv
// Scoreboard bench for nbit_serial_sub at n=8 and n=16: directed cases, then random ops.
module tb_nbit_serial_sub;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    nbit_serial_sub_if #(.n(8))  bus8 ();
    nbit_serial_sub_if #(.n(16)) bus16 ();

    nbit_serial_sub #(.n(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    nbit_serial_sub #(.n(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitors: pop the scoreboard on every done pulse, and check result hold while busy.
    initial begin
        logic [8:0] last8;
        logic [8:0] exp8;
        last8 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last8 = '0;
            end else begin
                if (bus8.busy) check("hold8", 32'({bus8.b_out, bus8.diff}), 32'(last8));
                if (bus8.done) begin
                    check("excl8", 32'(bus8.busy), 32'd0);
                    if (q8.size() == 0) begin
                        check("sb8_empty", 32'd0, 32'd1);
                    end else begin
                        exp8 = q8.pop_front();
                        check("res8", 32'({bus8.b_out, bus8.diff}), 32'(exp8));
                    end
                    last8 = {bus8.b_out, bus8.diff};
                end
            end
        end
    end

    initial begin
        logic [16:0] last16;
        logic [16:0] exp16;
        last16 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last16 = '0;
            end else begin
                if (bus16.busy) check("hold16", 32'({bus16.b_out, bus16.diff}), 32'(last16));
                if (bus16.done) begin
                    check("excl16", 32'(bus16.busy), 32'd0);
                    if (q16.size() == 0) begin
                        check("sb16_empty", 32'd0, 32'd1);
                    end else begin
                        exp16 = q16.pop_front();
                        check("res16", 32'({bus16.b_out, bus16.diff}), 32'(exp16));
                    end
                    last16 = {bus16.b_out, bus16.diff};
                end
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic sel);
        int         w;
        int         lat;
        logic [8:0] full;
        w = 0;
        @(negedge clk);
        while ((bus8.busy || bus8.done) && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) check("idle8_timeout", 32'd1, 32'd0);
        bus8.start  = 1'b1;
        bus8.select = sel;
        bus8.a      = a;
        bus8.b      = b;
        bus8.b_in   = bin;
        full = {1'b0, a} - {1'b0, b} - 9'(bin);
        q8.push_back(sel ? {1'b0, ~a} : full);
        @(negedge clk);
        bus8.start  = 1'b0;
        bus8.a      = 8'($urandom);
        bus8.b      = 8'($urandom);
        bus8.b_in   = 1'($urandom);
        bus8.select = 1'($urandom);
        if (sel) check("cmpl_busy8", 32'(bus8.busy), 32'd0);
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency8", 32'(lat), sel ? 32'd0 : 32'd8);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic sel);
        int          w;
        int          lat;
        logic [16:0] full;
        w = 0;
        @(negedge clk);
        while ((bus16.busy || bus16.done) && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) check("idle16_timeout", 32'd1, 32'd0);
        bus16.start  = 1'b1;
        bus16.select = sel;
        bus16.a      = a;
        bus16.b      = b;
        bus16.b_in   = bin;
        full = {1'b0, a} - {1'b0, b} - 17'(bin);
        q16.push_back(sel ? {1'b0, ~a} : full);
        @(negedge clk);
        bus16.start  = 1'b0;
        bus16.a      = 16'($urandom);
        bus16.b      = 16'($urandom);
        bus16.b_in   = 1'($urandom);
        bus16.select = 1'($urandom);
        if (sel) check("cmpl_busy16", 32'(bus16.busy), 32'd0);
        lat = 0;
        while (!bus16.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency16", 32'(lat), sel ? 32'd0 : 32'd16);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        {bus8.start, bus8.select, bus8.a, bus8.b, bus8.b_in}      = '0;
        {bus16.start, bus16.select, bus16.a, bus16.b, bus16.b_in} = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset8", 32'({bus8.diff, bus8.b_out, bus8.busy, bus8.done}), 32'd0);
        check("reset16", 32'({bus16.diff, bus16.b_out, bus16.busy, bus16.done}), 32'd0);

        op8(8'h3C, 8'h1A, 1'b0, 1'b0);
        op8(8'h05, 8'h07, 1'b0, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 1'b0);
        op8(8'hFF, 8'hFF, 1'b0, 1'b0);
        op8(8'hA5, 8'h00, 1'b0, 1'b1);

        // start held high through SHIFT/DONE with operands churning
        @(negedge clk);
        bus8.start  = 1'b1;
        bus8.select = 1'b0;
        bus8.a      = 8'h3C;
        bus8.b      = 8'h1A;
        bus8.b_in   = 1'b0;
        q8.push_back(9'h022);
        lat = 0;
        do begin
            @(negedge clk);
            bus8.a      = 8'($urandom);
            bus8.b      = 8'($urandom);
            bus8.b_in   = 1'($urandom);
            bus8.select = 1'($urandom);
            lat++;
        end while (!bus8.done && lat < 40);
        check("held_latency", 32'(lat), 32'd9);
        bus8.a      = 8'h50;
        bus8.b      = 8'h20;
        bus8.b_in   = 1'b0;
        bus8.select = 1'b0;
        q8.push_back(9'h030);
        @(negedge clk);
        check("held_idle_busy", 32'({bus8.busy, bus8.done}), 32'd0);
        @(negedge clk);
        bus8.start = 1'b0;
        check("held_reaccept", 32'(bus8.busy), 32'd1);
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("held_latency2", 32'(lat), 32'd8);

        // async reset in the 4th SHIFT cycle aborts the op
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h77;
        bus8.b     = 8'h11;
        bus8.b_in  = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst", 32'({bus8.diff, bus8.busy}), 32'({8'h30, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 32'({bus8.diff, bus8.b_out, bus8.busy, bus8.done}), 32'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op8(8'h10, 8'h01, 1'b0, 1'b0);

        fork
            for (int i = 0; i < 1000; i++)
                op8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
            for (int j = 0; j < 1000; j++)
                op16(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        join

        repeat (4) @(negedge clk);
        check("sb8_drain", 32'(q8.size()), 32'd0);
        check("sb16_drain", 32'(q16.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
